// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loadable pattern of 1..MAX_LEN bits.
// Provides a registered match pulse and a saturating match counter.
module seq_detect_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
  parameter logic [MAX_LEN-1:0] DEFAULT_PAT = 8'b0000_0110,
  parameter int                 DEFAULT_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               count_clr,
  output logic               y,
  output logic [CNT_W-1:0]   match_count
);

  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_y;
  logic [CNT_W-1:0]   r_count;

  logic               w_accept;
  logic [MAX_LEN-1:0] w_hist_shift;
  logic [LEN_W-1:0]   w_fill_inc;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_eq;
  logic               w_match;
  logic [LEN_W-1:0]   w_cfg_len_clamped;

  // Only the low r_len bits of history and pattern take part in the compare.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      assign w_mask[gi] = (r_len > LEN_W'(gi));
    end
  endgenerate

  assign w_accept          = in_valid & ~cfg_load;
  assign w_hist_shift      = {r_hist[MAX_LEN-2:0], in};
  assign w_fill_inc        = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
  assign w_eq              = (((w_hist_shift ^ r_pat) & w_mask) == '0);
  assign w_match           = w_accept & (r_len != '0) & (w_fill_inc >= r_len) & w_eq;
  assign w_cfg_len_clamped = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pat     <= DEFAULT_PAT;
      r_len     <= LEN_W'(DEFAULT_LEN);
      r_overlap <= 1'b1;
      r_hist    <= '0;
      r_fill    <= '0;
      r_y       <= 1'b0;
    end else begin
      r_y <= w_match;
      if (cfg_load) begin
        r_pat     <= cfg_pattern;
        r_len     <= w_cfg_len_clamped;
        r_overlap <= cfg_overlap;
        r_hist    <= '0;
        r_fill    <= '0;
      end else if (in_valid) begin
        r_hist <= w_hist_shift;
        // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
        r_fill <= (w_match && !r_overlap) ? '0 : w_fill_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (count_clr) begin
      r_count <= w_match ? CNT_W'(1) : '0;
    end else if (w_match && !(&r_count)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign y           = r_y;
  assign match_count = r_count;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed-vector bench for seq_detect_param; expected values are hand-derived
// from the detector's behaviour and compared through a single check task.
module tb_seq_detect_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               count_clr;
  logic               y;
  logic [CNT_W-1:0]   match_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_detect_param #(
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in         (in),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .count_clr  (count_clr),
    .y          (y),
    .match_count(match_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge with the given input; outputs are sampled 1ns after the edge.
  task automatic step(input logic v, input logic b);
    in_valid = v;
    in       = b;
    @(posedge clk);
    #1;
    $display("[TB] t=%0t rst=%b load=%b clr=%b valid=%b in=%b -> y=%b count=%0d",
             $time, rst, cfg_load, count_clr, v, b, y, match_count);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(1'b1, 1'b1);
    rst = 1'b1;
    chk("reset_y", {31'd0, y}, 32'd0);
    chk("reset_count", {24'd0, match_count}, 32'd0);
  endtask

  task automatic load(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                      input logic ov);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    step(1'b1, 1'b1);
    cfg_load = 1'b0;
    chk("load_y", {31'd0, y}, 32'd0);
  endtask

  // Sends n bits MSB-first from bits, checking y against exp_y bit by bit.
  task automatic stream(input string tag, input logic [15:0] bits, input int n,
                        input logic [15:0] exp_y);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, bits[i]);
      chk($sformatf("%s_y[%0d]", tag, n - i), {31'd0, y}, {31'd0, exp_y[i]});
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    in_valid    = 1'b0;
    in          = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    count_clr   = 1'b0;

    // Legacy 0110 overlapping behaviour after reset.
    do_reset();
    stream("t1", 16'b0110110, 7, 16'b0001001);
    chk("t1_count", {24'd0, match_count}, 32'd2);

    // Non-overlapping 0110.
    load(8'b0110, 4'd4, 1'b0);
    chk("t2_count_kept", {24'd0, match_count}, 32'd2);
    stream("t2", 16'b0110110, 7, 16'b0001000);
    chk("t2_count", {24'd0, match_count}, 32'd3);

    // 101 overlapping then non-overlapping.
    load(8'b101, 4'd3, 1'b1);
    stream("t3a", 16'b10101, 5, 16'b00101);
    chk("t3a_count", {24'd0, match_count}, 32'd5);
    load(8'b101, 4'd3, 1'b0);
    stream("t3b", 16'b10101, 5, 16'b00100);
    chk("t3b_count", {24'd0, match_count}, 32'd6);

    // Idle gaps between valid bits do not break the sequence.
    do_reset();
    begin
      logic [3:0] seq;
      seq = 4'b0110;
      for (int i = 3; i >= 0; i--) begin
        step(1'b1, seq[i]);
        chk($sformatf("t4_bit%0d_y", 4 - i), {31'd0, y}, (i == 0) ? 32'd1 : 32'd0);
        for (int k = 0; k < 3; k++) begin
          step(1'b0, 1'b1);
          chk($sformatf("t4_idle%0d_%0d_y", 4 - i, k), {31'd0, y}, 32'd0);
        end
      end
    end
    chk("t4_count", {24'd0, match_count}, 32'd1);

    // Reset mid-sequence discards the partial prefix.
    stream("t5a", 16'b011, 3, 16'b000);
    do_reset();
    stream("t5b", 16'b0, 1, 16'b0);
    stream("t5c", 16'b0110, 4, 16'b0001);
    chk("t5_count", {24'd0, match_count}, 32'd1);

    // Single-bit pattern: match every cycle, counter saturates.
    load(8'b1, 4'd1, 1'b1);
    for (int i = 1; i <= 300; i++) begin
      step(1'b1, 1'b1);
      chk($sformatf("t6_y[%0d]", i), {31'd0, y}, 32'd1);
      if (i == 253) chk("t6_count_253", {24'd0, match_count}, 32'd254);
    end
    chk("t6_count_sat", {24'd0, match_count}, 32'd255);

    // Clear coinciding with a match leaves the count at one.
    count_clr = 1'b1;
    step(1'b1, 1'b1);
    chk("t6_clr_match_y", {31'd0, y}, 32'd1);
    chk("t6_clr_match_count", {24'd0, match_count}, 32'd1);
    step(1'b0, 1'b0);
    count_clr = 1'b0;
    chk("t6_clr_idle_count", {24'd0, match_count}, 32'd0);

    // Oversized length clamps to MAX_LEN: eight ones then match.
    load(8'hFF, 4'd12, 1'b1);
    stream("t7", 16'b11111111, 8, 16'b00000001);
    chk("t7_count", {24'd0, match_count}, 32'd1);

    // Zero length disables detection.
    load(8'hFF, 4'd0, 1'b1);
    stream("t8", 16'b1111111111, 10, 16'b0);
    chk("t8_count", {24'd0, match_count}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised successor to the fixed 0110 serial sequence detector. Compares a serial bit stream against a runtime-loadable pattern of 1..MAX_LEN bits. Detection is overlapping or non-overlapping, selected at runtime. Provides a registered one-cycle match pulse and a saturating match counter. Sits on a serial input path as a drop-in detector; its reset configuration reproduces the legacy 0110 overlapping behaviour.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of match counter
LEN_W, $clog2(MAX_LEN+1), width of cfg_len (derived, not overridden)
DEFAULT_PAT, 8'b0000_0110, pattern after reset (LSB-aligned, MAX_LEN bits)
DEFAULT_LEN, 4, pattern length after reset

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-low
in_valid  input  1  in is sampled only when high
in  input  1  serial data bit
cfg_load  input  1  load strobe for cfg_pattern/cfg_len/cfg_overlap
cfg_pattern  input  MAX_LEN  new pattern; bit cfg_len-1 is the first bit expected, bit 0 the last
cfg_len  input  LEN_W  new pattern length
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
count_clr  input  1  synchronous clear of match_count
y  output  1  match pulse, registered
match_count  output  CNT_W  number of matches, saturating

Behaviour:
- Reset (rst==0 at edge): pat=DEFAULT_PAT, len=DEFAULT_LEN, overlap=1, hist=0, fill=0, y=0, match_count=0. Reset overrides all other inputs.
- State: hist[MAX_LEN-1:0] shift register; fill counter 0..MAX_LEN (saturating); pattern/len/overlap config registers.
- Accepted bit (in_valid=1, cfg_load=0): hist_next={hist[MAX_LEN-2:0],in}; fill_next=min(fill+1,MAX_LEN).
- match = accepted bit & (len!=0) & (fill_next>=len) & (hist_next[len-1:0]==pat[len-1:0]); upper bits are ignored.
- y <= match. Latency: y is high for exactly the one cycle after the edge that sampled the final pattern bit. y=0 in any cycle that follows an edge with no accepted bit.
- Overlap=1: hist and fill continue after a match, so a suffix of the match can begin the next match.
- Overlap=0: on match, fill_next=0 while hist still shifts. A new match needs len fresh bits.
- in_valid=0: hist and fill hold; idle gaps between bits do not break a sequence.
- cfg_load=1 has priority over in_valid in the same cycle; in is discarded. Latches pat=cfg_pattern, overlap=cfg_overlap, and len=cfg_len clamped to MAX_LEN when cfg_len>MAX_LEN. Clears hist, fill and y. Does not change match_count.
- len=0: detection disabled; y stays 0 and hist/fill still update.
- match_count: increments on match and saturates at 2^CNT_W-1.
- count_clr: match_count<=0. If count_clr and match occur in the same cycle, match_count<=1.
- Reset deasserted mid-sequence: history is lost; a partial prefix received before reset never completes a match.

Test Plan:
- Reset config, in_valid=1, stream 0,1,1,0,1,1,0 -> y pulses after bit 4 and after bit 7; match_count=2.
- Load pattern=0110, len=4, overlap=0; same stream 0110110 -> single y pulse after bit 4; match_count +1.
- Load pattern=101, len=3, overlap=1; stream 1,0,1,0,1 -> y after bits 3 and 5. Repeat with overlap=0 -> y after bit 3 only.
- Reset config, bits 0,1,1,0 with 3 idle in_valid=0 cycles between each bit -> exactly one y pulse, the cycle after the last valid 0. y=0 during all idle cycles.
- Send 0,1,1; pulse rst=0 for one cycle; send 0 -> no y. Then send 0,1,1,0 -> y=1 once. Check match_count=0 after reset and 1 after the match.
- Load pattern=1, len=1; 300 consecutive 1s -> y high every cycle and match_count saturates at 255. Assert count_clr on a match cycle -> match_count=1. Send cfg_len=12 -> len clamps to 8. Send cfg_len=0 -> y stays 0.
